ps2_key_receiver: RTL and testbench



---
 rtl/ps2_pkg.sv | 8 +
 rtl/ps2_line_filter.sv | 27 ++
 rtl/ps2_key_receiver.sv | 128 ++++++++++++
 tb/tb_ps2_key_receiver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix constants and frame FSM state encoding.
package ps2_pkg;
  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam int         PS2_PAUSE_SKIP = 7;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus FILTER_LEN-sample debounce for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line,
  output logic filt
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], line};
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 frame receiver and E0/F0/E1 prefix decoder producing the ps2_key event word.
// Optional watchdog abort of stalled frames when PS2_TIMEOUT_EN is defined.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 1600
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);
  logic       clk_f, data_f, clk_prev, fall_evt, timeout;
  ps2_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n, skip_cnt;
  logic [7:0] shreg, shreg_n;
  logic       par, par_n, byte_valid, valid_n, err_n, ext_flag, rel_flag;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys(clk_sys), .reset(reset), .line(ps2_clk), .filt(clk_f)
  );
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_sys(clk_sys), .reset(reset), .line(ps2_data), .filt(data_f)
  );

  assign fall_evt = clk_prev & ~clk_f;

`ifdef PS2_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) wd <= '0;
    else wd <= (state == IDLE || fall_evt) ? '0 : wd + 1'b1;
  end
  assign timeout = state != IDLE && !fall_evt && wd == WW'(TIMEOUT_CYC - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_prev   <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_prev   <= clk_f;
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      par        <= par_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else if (fall_evt) begin
      case (state)
        IDLE: begin
          state_n   = data_f ? IDLE : DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          shreg_n   = {data_f, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_n   = data_f;
          state_n = STOP;
        end
        default: begin
          valid_n = data_f & ^{shreg, par};
          err_n   = ~(data_f & ^{shreg, par});
          state_n = IDLE;
        end
      endcase
    end
  end

  // A rejected frame also discards any pending prefix or Pause skip.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key    <= '0;
      key_strobe <= 1'b0;
      ext_flag   <= 1'b0;
      rel_flag   <= 1'b0;
      skip_cnt   <= '0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_err) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
        skip_cnt <= '0;
      end else if (byte_valid) begin
        if (skip_cnt != 3'd0) skip_cnt <= skip_cnt - 1'b1;
        else if (shreg == PS2_PFX_PAUSE) skip_cnt <= 3'(PS2_PAUSE_SKIP);
        else if (shreg == PS2_PFX_EXT) ext_flag <= 1'b1;
        else if (shreg == PS2_PFX_REL) rel_flag <= 1'b1;
        else begin
          ps2_key    <= {~ps2_key[10], ~rel_flag, ext_flag, shreg};
          key_strobe <= 1'b1;
          ext_flag   <= 1'b0;
          rel_flag   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed plus randomized PS/2 frames checked against a byte-level event model.
// Build with PS2_TIMEOUT_EN to also exercise the watchdog.
module tb_ps2_key_receiver;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe, frame_err;

  int vectors = 0, miscompares = 0;
  int n_strobe = 0, n_err = 0, exp_strobe = 0, exp_err = 0;
  logic [10:0] exp_key = '0;
  bit m_ext = 0, m_rel = 0;
  int m_skip = 0;

  ps2_key_receiver dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_key(ps2_key), .key_strobe(key_strobe), .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (key_strobe) n_strobe++;
    if (frame_err) n_err++;
    if (key_strobe || frame_err) begin
      vectors++;
      assert (!(key_strobe && frame_err)) else begin
        miscompares++;
        $error("FAIL strobe_err_overlap: strobe=%0b err=%0b want not both", key_strobe, frame_err);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    cyc(4);
    ps2_clk = 1'b0;
    cyc($urandom_range(12, 25));
    ps2_clk = 1'b1;
    cyc($urandom_range(12, 25));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] bits;
    bits = {1'b1, ~^b ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
  endtask

  // Reference: each received byte interpreted by the prefix rules.
  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      exp_err++;
      m_ext = 0; m_rel = 0; m_skip = 0;
    end else if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_rel = 1;
    else begin
      exp_key = {~exp_key[10], ~m_rel, m_ext, b};
      exp_strobe++;
      m_ext = 0; m_rel = 0;
    end
  endtask

  task automatic check(input string tag, input logic [10:0] want);
    vectors++;
    assert (ps2_key === want) else begin
      miscompares++;
      $error("FAIL %s ps2_key: got %h want %h", tag, ps2_key, want);
    end
    vectors++;
    assert (n_strobe === exp_strobe) else begin
      miscompares++;
      $error("FAIL %s strobes: got %0d want %0d", tag, n_strobe, exp_strobe);
    end
    vectors++;
    assert (n_err === exp_err) else begin
      miscompares++;
      $error("FAIL %s frame_errs: got %0d want %0d", tag, n_err, exp_err);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit bad);
    send_frame(b, bad);
    model_byte(b, bad);
    cyc(30);
    check($sformatf("byte_%h_bad%0d", b, bad), exp_key);
  endtask

  initial begin
    logic [7:0] pause [8];
    logic [7:0] pfx [3];
    logic [7:0] b;
    pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    pfx = '{8'hE0, 8'hF0, 8'hE1};
    cyc(3);
    check("reset", 11'h000);
    vectors++;
    assert (key_strobe === 1'b0 && frame_err === 1'b0) else begin
      miscompares++;
      $error("FAIL reset_pulses: strobe=%0b err=%0b want 0 0", key_strobe, frame_err);
    end
    reset = 1'b0;
    cyc(5);

    xfer(8'h1C, 0);
    check("make_1C", 11'h61C);
    xfer(8'hF0, 0);
    xfer(8'h1C, 0);
    check("break_1C", 11'h01C);
    xfer(8'hE0, 0);
    xfer(8'h75, 0);
    check("ext_75", 11'h775);
    xfer(8'h1C, 0);
    check("plain_after_ext", 11'h21C);
    xfer(8'hE0, 0);
    xfer(8'h1C, 1);
    check("parity_err", 11'h21C);
    xfer(8'h1C, 0);
    check("after_err", 11'h61C);

    // Short clock glitch with data low, mimicking a false start bit.
    ps2_data = 1'b0;
    cyc(2);
    ps2_clk = 1'b0;
    cyc(5);
    ps2_clk = 1'b1;
    cyc(3);
    ps2_data = 1'b1;
    cyc(30);
    check("glitch_idle", exp_key);
    xfer(8'h2A, 0);
    check("after_glitch", 11'h22A);

    for (int i = 0; i < 8; i++) xfer(pause[i], 0);
    check("pause", 11'h22A);

    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 3) == 0) ? pfx[$urandom_range(0, 2)] : 8'($urandom);
      xfer(b, $urandom_range(0, 9) == 0);
    end

    // Reset in the middle of a frame drops it entirely.
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    reset = 1'b1;
    exp_key = '0; m_ext = 0; m_rel = 0; m_skip = 0;
    cyc(2);
    check("mid_reset", 11'h000);
    reset = 1'b0;
    cyc(5);
    xfer(8'h1C, 0);
    check("after_reset", 11'h61C);

`ifdef PS2_TIMEOUT_EN
    begin
      int waited;
      ps2_bit(1'b0);
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_data = 1'b0;
      cyc(4);
      ps2_clk = 1'b0;
      cyc(15);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      waited = 15;
      while (n_err == exp_err && waited < 1800) begin
        cyc(1);
        waited++;
      end
      vectors++;
      assert (waited >= 1580 && waited <= 1660) else begin
        miscompares++;
        $error("FAIL timeout_cycle: got %0d want 1580..1660", waited);
      end
      model_byte(8'h00, 1);
      cyc(30);
      check("timeout", exp_key);
      xfer(8'h1C, 0);
      check("after_timeout", 11'h21C);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
